// File: rtl/ste_led_bar_peak.sv
// LED bar-graph driver with bar/dot display and a peak indicator that holds,
// then decays one LED per step toward the current level.
module ste_led_bar_peak #(
    parameter int DATA_W    = 12,
    parameter int LED_NR    = 16,
    parameter int HOLD_CYC  = 50_000_000,
    parameter int DECAY_CYC = 5_000_000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_W-1:0]              din_i,
    input  logic                           din_update_i,
    input  logic                           clr_i,
    input  logic                           mode_i,
    input  logic                           peak_en_i,
    output logic [LED_NR-1:0]              led_o,
    output logic [$clog2(LED_NR+1)-1:0]    level_o,
    output logic [$clog2(LED_NR+1)-1:0]    peak_o
);

    localparam int LVL_W   = $clog2(LED_NR + 1);
    localparam int PROD_W  = DATA_W + LVL_W;
    localparam int CNT_MAX = (HOLD_CYC > DECAY_CYC) ? HOLD_CYC : DECAY_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DECAY = 2'd2
    } peak_state_t;

    peak_state_t         r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [LVL_W-1:0]    r_level;
    logic [LVL_W-1:0]    r_peak;
    logic [LED_NR-1:0]   r_led;

    logic [PROD_W-1:0]   w_prod;
    logic [LVL_W-1:0]    w_new_level;
    logic [LVL_W-1:0]    w_lvl_eff;
    logic [LVL_W-1:0]    w_peak_dec;
    logic [LVL_W-1:0]    w_decay_next;
    logic                w_peak_capture;
    logic [LED_NR-1:0]   w_led;

    // Scale the sample onto 0..LED_NR and work out the next peak candidates.
    always_comb begin
        w_prod         = PROD_W'(din_i) * PROD_W'(LED_NR + 1);
        w_new_level    = LVL_W'(w_prod >> DATA_W);
        // A decay step in the same cycle as an update must see the fresh level.
        w_lvl_eff      = din_update_i ? w_new_level : r_level;
        w_peak_capture = din_update_i && (w_new_level >= r_peak) && (w_new_level != LVL_W'(0));
        w_peak_dec     = (r_peak != LVL_W'(0)) ? (r_peak - LVL_W'(1)) : LVL_W'(0);
        w_decay_next   = (w_peak_dec > w_lvl_eff) ? w_peak_dec : w_lvl_eff;
    end

    // LED pattern from the registered level/peak and the live display controls.
    always_comb begin
        w_led = {LED_NR{1'b0}};
        for (int i = 0; i < LED_NR; i++) begin
            w_led[i] = (mode_i ? ((r_level != LVL_W'(0)) && (i == int'(r_level) - 1))
                               : (i < int'(r_level)))
                    || (peak_en_i && (r_peak != LVL_W'(0)) && (i == int'(r_peak) - 1));
        end
    end

    // Level capture, peak hold/decay FSM and registered LED drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= CNT_W'(0);
            r_level <= LVL_W'(0);
            r_peak  <= LVL_W'(0);
            r_led   <= {LED_NR{1'b0}};
        end else if (clr_i) begin
            r_state <= IDLE;
            r_cnt   <= CNT_W'(0);
            r_level <= LVL_W'(0);
            r_peak  <= LVL_W'(0);
            r_led   <= {LED_NR{1'b0}};
        end else begin
            r_led <= w_led;
            if (din_update_i) begin
                r_level <= w_new_level;
            end else begin
                r_level <= r_level;
            end
            if (w_peak_capture) begin
                r_peak  <= w_new_level;
                r_cnt   <= CNT_W'(HOLD_CYC - 1);
                r_state <= HOLD;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_cnt <= CNT_W'(0);
                    end
                    HOLD: begin
                        if (r_cnt == CNT_W'(0)) begin
                            r_cnt   <= CNT_W'(DECAY_CYC - 1);
                            r_state <= DECAY;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    DECAY: begin
                        if (r_cnt == CNT_W'(0)) begin
                            r_peak <= w_decay_next;
                            if (w_decay_next == LVL_W'(0)) begin
                                r_cnt   <= CNT_W'(0);
                                r_state <= IDLE;
                            end else begin
                                r_cnt <= CNT_W'(DECAY_CYC - 1);
                            end
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        r_cnt   <= CNT_W'(0);
                        r_peak  <= LVL_W'(0);
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign led_o   = r_led;
    assign level_o = r_level;
    assign peak_o  = r_peak;

endmodule

// File: tb/tb_ste_led_bar_peak.sv
// Directed bench for ste_led_bar_peak with DATA_W=4, LED_NR=8, HOLD_CYC=4, DECAY_CYC=2.
module tb_ste_led_bar_peak;

    logic       clk;
    logic       rst_n;
    logic [3:0] din_i;
    logic       din_update_i;
    logic       clr_i;
    logic       mode_i;
    logic       peak_en_i;
    logic [7:0] led_o;
    logic [3:0] level_o;
    logic [3:0] peak_o;

    int n_run  = 0;
    int n_fail = 0;

    ste_led_bar_peak #(
        .DATA_W   (4),
        .LED_NR   (8),
        .HOLD_CYC (4),
        .DECAY_CYC(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din_i       (din_i),
        .din_update_i(din_update_i),
        .clr_i       (clr_i),
        .mode_i      (mode_i),
        .peak_en_i   (peak_en_i),
        .led_o       (led_o),
        .level_o     (level_o),
        .peak_o      (peak_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; din_i = 4'd0; din_update_i = 1'b0; clr_i = 1'b0;
        mode_i = 1'b0; peak_en_i = 1'b0;
        #12;
        chk("rst_led",   16'(led_o),   16'h00);
        chk("rst_level", 16'(level_o), 16'd0);
        chk("rst_peak",  16'(peak_o),  16'd0);

        // bar mode, mid-scale
        rst_n = 1'b1; din_i = 4'd8; din_update_i = 1'b1;
        tick(1);
        chk("bar_level4", 16'(level_o), 16'd4);
        chk("bar_led_lag", 16'(led_o), 16'h00);
        din_update_i = 1'b0;
        tick(1);
        chk("bar_led4", 16'(led_o), 16'h0F);

        // full scale, then drop; peak holds and decays
        peak_en_i = 1'b1; din_i = 4'd15; din_update_i = 1'b1;
        tick(1);
        chk("full_level", 16'(level_o), 16'd8);
        chk("full_peak",  16'(peak_o),  16'd8);
        din_i = 4'd2;
        tick(1);
        chk("drop_level", 16'(level_o), 16'd1);
        chk("drop_peak",  16'(peak_o),  16'd8);
        din_update_i = 1'b0;
        tick(1);
        chk("peak_led", 16'(led_o), 16'h81);
        tick(3);
        chk("hold_end_peak", 16'(peak_o), 16'd8);
        tick(1);
        chk("decay_peak7", 16'(peak_o), 16'd7);
        for (int k = 6; k >= 1; k--) begin
            tick(2);
            chk("decay_step", 16'(peak_o), 16'(k));
        end
        tick(4);
        chk("settle_peak", 16'(peak_o), 16'd1);
        chk("settle_led",  16'(led_o),  16'h01);

        // dot mode
        mode_i = 1'b1; peak_en_i = 1'b0; din_i = 4'd8; din_update_i = 1'b1;
        tick(1);
        chk("dot_level", 16'(level_o), 16'd4);
        din_update_i = 1'b0;
        tick(1);
        chk("dot_led", 16'(led_o), 16'h08);
        din_i = 4'd1; din_update_i = 1'b1;
        tick(1);
        chk("dot_level0", 16'(level_o), 16'd0);
        din_update_i = 1'b0;
        tick(1);
        chk("dot_led0", 16'(led_o), 16'h00);

        // update during decay restarts the hold
        mode_i = 1'b0; clr_i = 1'b1;
        tick(1);
        chk("clr_peak", 16'(peak_o), 16'd0);
        clr_i = 1'b0; din_i = 4'd11; din_update_i = 1'b1;
        tick(1);
        chk("p6_peak", 16'(peak_o), 16'd6);
        din_i = 4'd0;
        tick(1);
        din_update_i = 1'b0;
        tick(5);
        chk("p5_first", 16'(peak_o), 16'd5);
        tick(1);
        chk("p5_second", 16'(peak_o), 16'd5);
        din_i = 4'd15; din_update_i = 1'b1;
        tick(1);
        chk("reup_peak", 16'(peak_o), 16'd8);
        din_i = 4'd0;
        tick(1);
        din_update_i = 1'b0;
        tick(4);
        chk("rehold_peak", 16'(peak_o), 16'd8);
        tick(1);
        chk("redecay_peak", 16'(peak_o), 16'd7);

        // clear beats a simultaneous update
        peak_en_i = 1'b1; clr_i = 1'b1; din_i = 4'd15; din_update_i = 1'b1;
        tick(1);
        chk("clrupd_level", 16'(level_o), 16'd0);
        chk("clrupd_peak",  16'(peak_o),  16'd0);
        chk("clrupd_led",   16'(led_o),   16'h00);
        clr_i = 1'b0; din_update_i = 1'b0;
        tick(1);
        chk("clr_after_led", 16'(led_o), 16'h00);

        // asynchronous reset mid-hold
        din_i = 4'd15; din_update_i = 1'b1;
        tick(1);
        din_update_i = 1'b0;
        tick(1);
        chk("prerst_led", 16'(led_o), 16'hFF);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_led",   16'(led_o),   16'h00);
        chk("arst_level", 16'(level_o), 16'd0);
        chk("arst_peak",  16'(peak_o),  16'd0);
        #1;
        rst_n = 1'b1; din_i = 4'd8; din_update_i = 1'b1;
        tick(1);
        chk("post_rst_level", 16'(level_o), 16'd4);
        chk("post_rst_peak",  16'(peak_o),  16'd4);
        din_update_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/ste_led_bar_peak.md
STE_LED_BAR_PEAK -- requirements
Module: ste_led_bar_peak

Interface
REQ-001 SHALL have parameter DATA_W, default 12, input sample width in bits (2..16).
REQ-002 SHALL have parameter LED_NR, default 16, number of bar LEDs (1..64).
REQ-003 SHALL have parameter HOLD_CYC, default 50_000_000, peak hold time in clk cycles (>=1).
REQ-004 SHALL have parameter DECAY_CYC, default 5_000_000, clk cycles per one-LED peak decay step (>=1).
REQ-005 SHALL have port clk  input  1  system clock; one clock domain only.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port din_i  input  DATA_W  unsigned magnitude sample.
REQ-008 SHALL have port din_update_i  input  1  single-cycle strobe, din_i valid.
REQ-009 SHALL have port clr_i  input  1  synchronous clear.
REQ-010 SHALL have port mode_i  input  1  display mode: 0 bar, 1 dot.
REQ-011 SHALL have port peak_en_i  input  1  peak indicator display enable.
REQ-012 SHALL have port led_o  output  LED_NR  registered LED drive, bit 0 = lowest LED.
REQ-013 SHALL have port level_o  output  $clog2(LED_NR+1)  current bar level 0..LED_NR.
REQ-014 SHALL have port peak_o  output  $clog2(LED_NR+1)  current peak level 0..LED_NR.

Function
REQ-015 Level SHALL be (din_i * (LED_NR+1)) >> DATA_W, product width DATA_W+$clog2(LED_NR+1), no truncation; din_i=0 gives 0, full scale gives LED_NR.
REQ-016 level_o SHALL update on the edge sampling din_update_i=1 and hold otherwise.
REQ-017 led_o SHALL be a registered function of level_o, peak_o, mode_i, peak_en_i, recomputed every cycle (led_o lags level_o by one cycle; mode changes visible one cycle later).
REQ-018 Bar mode: led_o[i]=1 for all i < level_o; level 0 SHALL light no LED.
REQ-019 Dot mode: only led_o[level_o-1]=1 when level_o>0; none when 0.
REQ-020 When peak_en_i=1 and peak_o>0, led_o[peak_o-1] SHALL additionally be set (OR overlay); peak_en_i=0 hides it but peak tracking continues.
REQ-021 Peak FSM SHALL have states IDLE (peak 0), HOLD, DECAY.
REQ-022 On update with new level >= peak_o and new level > 0: peak_o <= new level, hold counter loaded HOLD_CYC-1, state HOLD (from any state, incl. HOLD/DECAY).
REQ-023 HOLD: counter decrements each cycle; at 0 SHALL go to DECAY with decay counter loaded DECAY_CYC-1.
REQ-024 DECAY: counter decrements each cycle; at 0 peak_o <= max(peak_o-1, level_o) and counter reloaded; peak_o reaching 0 SHALL go to IDLE.
REQ-025 Update rule (REQ-022) SHALL take priority over a decay step in the same cycle; the decay step SHALL use the newly captured level.
REQ-026 peak_o SHALL never be below level_o nor exceed LED_NR.
REQ-027 clr_i=1 SHALL, at the next edge, zero level_o, peak_o, led_o, both counters and enter IDLE; clr_i wins over simultaneous din_update_i.

Reset
REQ-028 rst_n=0 SHALL immediately, without a clock edge, force led_o=0, level_o=0, peak_o=0, counters 0, state IDLE.
REQ-029 Reset release SHALL resume operation on the first edge with rst_n=1; no update is lost-sampled during reset.

Verification (DATA_W=4, LED_NR=8, HOLD_CYC=4, DECAY_CYC=2)
REQ-030 Reset, then update din=8, mode 0, peak_en 0 -> level_o=4 after update edge, led_o=0x0F one edge later.
REQ-031 Update din=15 then din=2, peak_en 1 -> peak_o=8, led_o=0x81; after 4 hold cycles peak_o steps 7,6,...,1 every 2 cycles, settling at 1 (led_o=0x01).
REQ-032 Mode 1, peak_en 0, update din=8 -> led_o=0x08; din=1 -> level_o=0, led_o=0x00.
REQ-033 During DECAY (peak_o=5) update din=15 -> peak_o=8, state HOLD, hold restarted, no decay step that cycle.
REQ-034 clr_i and din_update_i (din=15) same cycle -> level_o=0, peak_o=0, led_o=0x00.
REQ-035 rst_n low mid-HOLD between clock edges -> all outputs 0 before the next edge.
